// File: rtl/muldiv_ctrl_pkg.sv
// mips_defs: shared opcode/func codes, FSM states and op-kind encodings for the HI/LO unit
package mips_defs;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV = 6'b011010;
  localparam logic [5:0] F_DIVU = 6'b011011;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  // low two func bits of MULT/MULTU/DIV/DIVU map directly onto this encoding
  typedef enum logic [1:0] {MUL_S, MUL_U, DIV_S, DIV_U} kind_t;
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage request and HI/LO result bundle
interface muldiv_ctrl_if;
  logic ex_valid;
  logic [5:0] ex_op;
  logic [5:0] ex_func;
  logic [31:0] ex_busA;
  logic [31:0] ex_busB;
  logic abort;
  logic stall;
  logic busy;
  logic [31:0] hi_num;
  logic [31:0] lo_num;
  modport master(output ex_valid, ex_op, ex_func, ex_busA, ex_busB, abort, input stall, busy, hi_num, lo_num);
  modport slave(input ex_valid, ex_op, ex_func, ex_busA, ex_busB, abort, output stall, busy, hi_num, lo_num);
endinterface

// File: rtl/muldiv_ctrl_iter.sv
// muldiv_iter: 64-bit accumulator doing one shift-add or restoring-divide step per enable, with sign fixup
module muldiv_iter
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  kind_t       kind,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);
  logic [63:0] acc, nxt, prod;
  logic [31:0] m, ma, mb;
  logic [32:0] sum, diff;
  logic [64:0] sh;
  logic sgn, sa, sb, dz, mul, neg;
  kind_t k;
  assign sgn = kind == MUL_S || kind == DIV_S;
  assign ma = sgn && a[31] ? -a : a;
  assign mb = sgn && b[31] ? -b : b;
  assign mul = k == MUL_S || k == MUL_U;
  assign neg = sa ^ sb;
  // one iteration: multiply adds m into the high half then shifts right; divide shifts left and trial-subtracts
  always_comb begin
    sum = {1'b0, acc[63:32]} + {1'b0, m};
    sh = {acc, 1'b0};
    diff = sh[64:32] - {1'b0, m};
    nxt = mul ? (acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]})
              : (diff[32] ? sh[63:0] : {diff[31:0], sh[31:1], 1'b1});
  end
  // operand magnitudes and signs are captured at load so the EX buses may change afterwards
  always_ff @(posedge clk)
    if (load) begin
      acc <= {32'd0, ma};
      m <= mb;
      k <= kind;
      sa <= sgn & a[31];
      sb <= sgn & b[31];
      dz <= b == 32'd0;
    end else if (step) acc <= nxt;
  // remainder follows the dividend's sign; a zero divisor leaves |A| as remainder, which fixes back to A
  always_comb begin
    prod = neg ? -acc : acc;
    hi_res = mul ? prod[63:32] : (sa ? -acc[63:32] : acc[63:32]);
    lo_res = mul ? prod[31:0] : dz ? 32'hFFFF_FFFF : (neg ? -acc[31:0] : acc[31:0]);
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner with decode, iterative mult/div sequencing and pipeline stall
module muldiv_ctrl
  import mips_defs::*;
(
  input logic clk,
  input logic rst_n,
  muldiv_ctrl_if.slave bus
);
  state_t state, state_n;
  logic [4:0] cnt;
  logic [31:0] hi, lo, hi_res, lo_res;
  logic is_sp, is_start, is_move, accept, wr_fix, mthi, mtlo, busy_q;
  assign is_sp = bus.ex_valid && bus.ex_op == OP_SPECIAL;
  assign is_start = is_sp && bus.ex_func inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  assign is_move = is_sp && bus.ex_func inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO};
  assign accept = state == IDLE && is_start && !bus.abort;
  assign wr_fix = state == FIX && !bus.abort;
  assign mthi = state == IDLE && is_sp && bus.ex_func == F_MTHI && !bus.abort;
  assign mtlo = state == IDLE && is_sp && bus.ex_func == F_MTLO && !bus.abort;
  assign bus.stall = (is_start || is_move) && busy_q;
  assign bus.busy = busy_q;
  assign bus.hi_num = hi;
  assign bus.lo_num = lo;
  // next state: abort wins everywhere; CALC runs 32 iterations before the fixup cycle
  always_comb begin
    state_n = bus.abort ? IDLE
            : state == IDLE ? (accept ? CALC : IDLE)
            : state == CALC ? (cnt == 5'd31 ? FIX : CALC)
            : IDLE;
  end
  // state, iteration counter and registered busy flag
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      busy_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == CALC ? cnt + 5'd1 : '0;
      busy_q <= state_n != IDLE;
    end
  // HI/LO: result write from FIX, otherwise direct moves while idle
  always_ff @(posedge clk)
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_fix) begin
      hi <= hi_res;
      lo <= lo_res;
    end else begin
      if (mthi) hi <= bus.ex_busA;
      if (mtlo) lo <= bus.ex_busA;
    end
  muldiv_iter u_iter (
    .clk(clk),
    .load(accept),
    .step(state == CALC),
    .kind(kind_t'(bus.ex_func[1:0])),
    .a(bus.ex_busA),
    .b(bus.ex_busB),
    .hi_res(hi_res),
    .lo_res(lo_res)
  );
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed checks of muldiv_ctrl results, timing, stall, moves and abort/reset
module tb_muldiv_ctrl;
  import mips_defs::*;
  localparam logic [5:0] F_ADDU = 6'b100001;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  muldiv_ctrl_if bus();
  muldiv_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.ex_valid = v;
    bus.ex_op = OP_SPECIAL;
    bus.ex_func = f;
    bus.ex_busA = a;
    bus.ex_busB = b;
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int cyc);
    drive(1'b1, f, a, b);
    tick();
    drive(1'b0, F_ADDU, 32'd0, 32'd0);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    bus.abort = 1'b0;
    drive(1'b1, F_MFHI, 32'd0, 32'd0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_chk++; if (bus.hi_num !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi_num); end
    n_chk++; if (bus.lo_num !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo_num); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    drive(1'b0, F_ADDU, 32'd0, 32'd0);
  endtask

  task automatic test_muldiv();
    logic [5:0] f [8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_DIV, F_DIVU, F_DIV, F_MULT};
    logic [31:0] a [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd5, 32'd7, 32'd100, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] b [8] = '{32'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 32'd7, 32'd0, 32'hFFFFFFFF};
    logic [31:0] eh [8] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd5, 32'd1, 32'd2, 32'hFFFFFFF9, 32'd0};
    logic [31:0] el [8] = '{32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000};
    int cyc;
    for (int i = 0; i < 8; i++) begin
      run_op(f[i], a[i], b[i], cyc);
      n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL busy_cycles[%0d]: got %0d expected 33", i, cyc); end
      n_chk++; if (bus.hi_num !== eh[i]) begin n_fail++; $display("FAIL hi[%0d]: got %h expected %h", i, bus.hi_num, eh[i]); end
      n_chk++; if (bus.lo_num !== el[i]) begin n_fail++; $display("FAIL lo[%0d]: got %h expected %h", i, bus.lo_num, el[i]); end
    end
  endtask

  task automatic test_pipeline();
    int n;
    drive(1'b1, F_MFHI, 32'd0, 32'd0);
    #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mfhi_idle_stall: got %b expected 0", bus.stall); end
    drive(1'b1, F_MULT, 32'd3, 32'd5);
    tick();
    bus.ex_func = F_ADDU;
    #1;
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL alu1_stall: got %b expected 0", bus.stall); end
    tick();
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL alu2_stall: got %b expected 0", bus.stall); end
    tick();
    bus.ex_func = F_MFLO;
    #1;
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      tick();
    end
    n_chk++; if (n !== 31) begin n_fail++; $display("FAIL mflo_stall_cycles: got %0d expected 31", n); end
    n_chk++; if (bus.lo_num !== 32'd15) begin n_fail++; $display("FAIL mflo_value: got %h expected 0000000f", bus.lo_num); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mflo_release_busy: got %b expected 0", bus.busy); end
    drive(1'b0, F_ADDU, 32'd0, 32'd0);
  endtask

  task automatic test_move();
    int n;
    drive(1'b1, F_MTHI, 32'h12345678, 32'd0);
    tick();
    n_chk++; if (bus.hi_num !== 32'h12345678) begin n_fail++; $display("FAIL mthi_hi: got %h expected 12345678", bus.hi_num); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b expected 0", bus.busy); end
    drive(1'b1, F_MULTU, 32'd2, 32'd3);
    tick();
    drive(1'b1, F_MTLO, 32'hAABBCCDD, 32'd0);
    #1;
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      tick();
    end
    n_chk++; if (n !== 33) begin n_fail++; $display("FAIL mtlo_stall_cycles: got %0d expected 33", n); end
    n_chk++; if (bus.lo_num !== 32'd6) begin n_fail++; $display("FAIL mtlo_pre_lo: got %h expected 00000006", bus.lo_num); end
    tick();
    drive(1'b0, F_ADDU, 32'd0, 32'd0);
    n_chk++; if (bus.lo_num !== 32'hAABBCCDD) begin n_fail++; $display("FAIL mtlo_lo: got %h expected aabbccdd", bus.lo_num); end
    n_chk++; if (bus.hi_num !== 32'd0) begin n_fail++; $display("FAIL mtlo_hi: got %h expected 00000000", bus.hi_num); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    drive(1'b1, F_MULTU, 32'd2, 32'd3);
    tick();
    drive(1'b1, F_DIVU, 32'd100, 32'd7);
    #1;
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      tick();
    end
    n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL b2b_first_cycles: got %0d expected 33", cyc); end
    n_chk++; if (bus.lo_num !== 32'd6) begin n_fail++; $display("FAIL b2b_first_lo: got %h expected 00000006", bus.lo_num); end
    n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL b2b_release_stall: got %b expected 0", bus.stall); end
    tick();
    drive(1'b0, F_ADDU, 32'd0, 32'd0);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got %b expected 1", bus.busy); end
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      tick();
    end
    n_chk++; if (bus.lo_num !== 32'd14) begin n_fail++; $display("FAIL b2b_quot: got %h expected 0000000e", bus.lo_num); end
    n_chk++; if (bus.hi_num !== 32'd2) begin n_fail++; $display("FAIL b2b_rem: got %h expected 00000002", bus.hi_num); end
  endtask

  task automatic test_abort();
    int cyc;
    drive(1'b1, F_MULT, 32'd3, 32'd5);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    drive(1'b0, F_ADDU, 32'd0, 32'd0);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_blocks_accept: got %b expected 0", bus.busy); end
    drive(1'b1, F_MULT, 32'd3, 32'd5);
    tick();
    drive(1'b0, F_ADDU, 32'd0, 32'd0);
    repeat (10) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    n_chk++; if (bus.hi_num !== 32'd2) begin n_fail++; $display("FAIL abort_hi: got %h expected 00000002", bus.hi_num); end
    n_chk++; if (bus.lo_num !== 32'd14) begin n_fail++; $display("FAIL abort_lo: got %h expected 0000000e", bus.lo_num); end
    run_op(F_MULT, 32'd7, 32'hFFFFFFFA, cyc);
    n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL post_abort_cycles: got %0d expected 33", cyc); end
    n_chk++; if (bus.lo_num !== 32'hFFFFFFD6) begin n_fail++; $display("FAIL post_abort_lo: got %h expected ffffffd6", bus.lo_num); end
    n_chk++; if (bus.hi_num !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL post_abort_hi: got %h expected ffffffff", bus.hi_num); end
    drive(1'b1, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    drive(1'b0, F_ADDU, 32'd0, 32'd0);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    n_chk++; if (bus.hi_num !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hi: got %h expected 00000000", bus.hi_num); end
    n_chk++; if (bus.lo_num !== 32'd0) begin n_fail++; $display("FAIL rst_mid_lo: got %h expected 00000000", bus.lo_num); end
    run_op(F_MULTU, 32'd9, 32'd9, cyc);
    n_chk++; if (bus.lo_num !== 32'd81) begin n_fail++; $display("FAIL post_rst_lo: got %h expected 00000051", bus.lo_num); end
  endtask

  initial begin
    bus.abort = 1'b0;
    drive(1'b0, F_ADDU, 32'd0, 32'd0);
    test_reset();
    test_muldiv();
    test_pipeline();
    test_move();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
